// File: rtl/mips_defs_pkg.sv
// Shared MIPS definitions for the decode stage: opcodes, ALUOp encodings,
// control-bundle bit positions and the main-control decode function.
// Optional feature macro used by this slice: IDECODE_BYPASS_EN (regfile).
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // wb bundle: {RegWrite, MemtoReg}
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    // m bundle: {Branch, MemRead, MemWrite}
    localparam int M_BRANCH    = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;
    // ex bundle: {RegDst, ALUOp[1:0], ALUSrc}
    localparam int EX_REGDST   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUSRC   = 0;

    typedef struct packed {
        logic [1:0] wb;
        logic [2:0] m;
        logic [3:0] ex;
    } ctrl_t;

    // Main control; unknown opcodes decode to an all-zero bubble.
    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_RTYPE: begin
                c.wb[WB_REGWRITE]               = 1'b1;
                c.ex[EX_REGDST]                 = 1'b1;
                c.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_FUNCT;
            end
            OP_LW: begin
                c.wb[WB_REGWRITE]               = 1'b1;
                c.wb[WB_MEMTOREG]               = 1'b1;
                c.m[M_MEMREAD]                  = 1'b1;
                c.ex[EX_ALUSRC]                 = 1'b1;
                c.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_ADD;
            end
            OP_SW: begin
                c.m[M_MEMWRITE]                 = 1'b1;
                c.ex[EX_ALUSRC]                 = 1'b1;
                c.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_ADD;
            end
            OP_BEQ: begin
                c.m[M_BRANCH]                   = 1'b1;
                c.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_SUB;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/idecode_regfile.sv
// 32x32 register file, two combinational reads, one synchronous write.
// r0 always reads zero and is never written.
// IDECODE_BYPASS_EN: a same-cycle write to a read register is forwarded.
module regfile
    import mips_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_raddr1,
    input  logic [4:0]  i_raddr2,
    output logic [31:0] o_rdata1,
    output logic [31:0] o_rdata2,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata
);

    logic [31:0] r_mem [0:31];
    logic        w_we;

    assign w_we = i_we && (i_waddr != 5'd0);

    // Storage update; reset clears every register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read ports with r0 forced to zero and optional write-through.
    always_comb begin
        o_rdata1 = '0;
        o_rdata2 = '0;
        if (i_raddr1 != 5'd0) begin
            o_rdata1 = r_mem[i_raddr1];
        end
        if (i_raddr2 != 5'd0) begin
            o_rdata2 = r_mem[i_raddr2];
        end
`ifdef IDECODE_BYPASS_EN
        if (w_we && (i_waddr == i_raddr1)) begin
            o_rdata1 = i_wdata;
        end
        if (w_we && (i_waddr == i_raddr2)) begin
            o_rdata2 = i_wdata;
        end
`else
        // Without bypass the old value is returned; hazards are handled upstream.
`endif
    end

endmodule

// File: rtl/idecode.sv
// MIPS instruction-decode stage: register read, sign extension, main
// control decode and the ID/EX pipeline latch with branch squash.
// Optional feature macro: IDECODE_BYPASS_EN (write-through in regfile).
module idecode
    import mips_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IF_ID_instr,
    input  logic [31:0] IF_ID_npc,
    input  logic        EX_MEM_PCSrc,
    input  logic        MEM_WB_RegWrite,
    input  logic [4:0]  MEM_WB_WriteReg,
    input  logic [31:0] MEM_WB_WriteData,
    output logic [1:0]  ID_EX_wb,
    output logic [2:0]  ID_EX_m,
    output logic [3:0]  ID_EX_ex,
    output logic [31:0] ID_EX_npc,
    output logic [31:0] ID_EX_readdat1,
    output logic [31:0] ID_EX_readdat2,
    output logic [31:0] ID_EX_sign_ext,
    output logic [4:0]  ID_EX_instr_2016,
    output logic [4:0]  ID_EX_instr_1511
);

    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [15:0] w_imm;
    logic [31:0] w_rdata1;
    logic [31:0] w_rdata2;
    logic [31:0] w_sign_ext;
    ctrl_t       w_ctrl;

    assign w_opcode   = IF_ID_instr[31:26];
    assign w_rs       = IF_ID_instr[25:21];
    assign w_rt       = IF_ID_instr[20:16];
    assign w_rd       = IF_ID_instr[15:11];
    assign w_imm      = IF_ID_instr[15:0];
    assign w_sign_ext = {{16{w_imm[15]}}, w_imm};

    regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_raddr1 (w_rs),
        .i_raddr2 (w_rt),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2),
        .i_we     (MEM_WB_RegWrite),
        .i_waddr  (MEM_WB_WriteReg),
        .i_wdata  (MEM_WB_WriteData)
    );

    // Main control decode from the opcode.
    always_comb begin
        w_ctrl = decode_ctrl(w_opcode);
    end

    // ID/EX latch; a taken branch turns the control bundles into a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ID_EX_wb         <= '0;
            ID_EX_m          <= '0;
            ID_EX_ex         <= '0;
            ID_EX_npc        <= '0;
            ID_EX_readdat1   <= '0;
            ID_EX_readdat2   <= '0;
            ID_EX_sign_ext   <= '0;
            ID_EX_instr_2016 <= '0;
            ID_EX_instr_1511 <= '0;
        end else begin
            if (EX_MEM_PCSrc) begin
                ID_EX_wb <= '0;
                ID_EX_m  <= '0;
                ID_EX_ex <= '0;
            end else begin
                ID_EX_wb <= w_ctrl.wb;
                ID_EX_m  <= w_ctrl.m;
                ID_EX_ex <= w_ctrl.ex;
            end
            ID_EX_npc        <= IF_ID_npc;
            ID_EX_readdat1   <= w_rdata1;
            ID_EX_readdat2   <= w_rdata2;
            ID_EX_sign_ext   <= w_sign_ext;
            ID_EX_instr_2016 <= w_rt;
            ID_EX_instr_1511 <= w_rd;
        end
    end

endmodule

// File: tb/tb_idecode.sv
// Table-driven bench for idecode plus hand sequences for reset corners.
module tb_idecode;

    logic        clk;
    logic        rst;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_npc;
    logic        EX_MEM_PCSrc;
    logic        MEM_WB_RegWrite;
    logic [4:0]  MEM_WB_WriteReg;
    logic [31:0] MEM_WB_WriteData;
    logic [1:0]  ID_EX_wb;
    logic [2:0]  ID_EX_m;
    logic [3:0]  ID_EX_ex;
    logic [31:0] ID_EX_npc;
    logic [31:0] ID_EX_readdat1;
    logic [31:0] ID_EX_readdat2;
    logic [31:0] ID_EX_sign_ext;
    logic [4:0]  ID_EX_instr_2016;
    logic [4:0]  ID_EX_instr_1511;

    int total = 0;
    int bad   = 0;

    idecode dut (
        .clk              (clk),
        .rst              (rst),
        .IF_ID_instr      (IF_ID_instr),
        .IF_ID_npc        (IF_ID_npc),
        .EX_MEM_PCSrc     (EX_MEM_PCSrc),
        .MEM_WB_RegWrite  (MEM_WB_RegWrite),
        .MEM_WB_WriteReg  (MEM_WB_WriteReg),
        .MEM_WB_WriteData (MEM_WB_WriteData),
        .ID_EX_wb         (ID_EX_wb),
        .ID_EX_m          (ID_EX_m),
        .ID_EX_ex         (ID_EX_ex),
        .ID_EX_npc        (ID_EX_npc),
        .ID_EX_readdat1   (ID_EX_readdat1),
        .ID_EX_readdat2   (ID_EX_readdat2),
        .ID_EX_sign_ext   (ID_EX_sign_ext),
        .ID_EX_instr_2016 (ID_EX_instr_2016),
        .ID_EX_instr_1511 (ID_EX_instr_1511)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] npc;
        logic        pcsrc;
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sext;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(
        input logic [31:0] instr, input logic [31:0] npc, input logic pcsrc,
        input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
        input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
        input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] sext,
        input logic [4:0] rt, input logic [4:0] rd);
        vec_t v;
        v.instr = instr; v.npc = npc; v.pcsrc = pcsrc;
        v.we = we; v.wreg = wreg; v.wdata = wdata;
        v.wb = wb; v.m = m; v.ex = ex;
        v.rd1 = rd1; v.rd2 = rd2; v.sext = sext; v.rt = rt; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, " wb"},   {30'd0, ID_EX_wb},          {30'd0, v.wb});
        chk({tag, " m"},    {29'd0, ID_EX_m},           {29'd0, v.m});
        chk({tag, " ex"},   {28'd0, ID_EX_ex},          {28'd0, v.ex});
        chk({tag, " npc"},  ID_EX_npc,                  v.npc);
        chk({tag, " rd1"},  ID_EX_readdat1,             v.rd1);
        chk({tag, " rd2"},  ID_EX_readdat2,             v.rd2);
        chk({tag, " sext"}, ID_EX_sign_ext,             v.sext);
        chk({tag, " rt"},   {27'd0, ID_EX_instr_2016},  {27'd0, v.rt});
        chk({tag, " rd"},   {27'd0, ID_EX_instr_1511},  {27'd0, v.rd});
    endtask

    task automatic drive(input vec_t v);
        IF_ID_instr      = v.instr;
        IF_ID_npc        = v.npc;
        EX_MEM_PCSrc     = v.pcsrc;
        MEM_WB_RegWrite  = v.we;
        MEM_WB_WriteReg  = v.wreg;
        MEM_WB_WriteData = v.wdata;
    endtask

    task automatic chk_zero(input string tag);
        vec_t z;
        z = mkv(0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 4'b0000, 0, 0, 0, 0, 0);
        chk_all(tag, z);
    endtask

    initial begin
        vec_t v;
        logic [31:0] byp_r7_a;
        logic [31:0] byp_r7_b;

`ifdef IDECODE_BYPASS_EN
        byp_r7_a = 32'h0000_1234;
        byp_r7_b = 32'h0000_5678;
`else
        byp_r7_a = 32'h0000_0000;
        byp_r7_b = 32'h0000_1234;
`endif

        // Writes of r3/r4, then decode of each instruction class.
        vecs.push_back(mkv(32'h0000_0000, 32'h100, 0, 1, 5'd3, 32'hAA, 2'b10, 3'b000, 4'b1100, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(32'h0000_0000, 32'h104, 0, 1, 5'd4, 32'h55, 2'b10, 3'b000, 4'b1100, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(32'h0064_2820, 32'h008, 0, 0, 5'd0, 0, 2'b10, 3'b000, 4'b1100, 32'hAA, 32'h55, 32'h2820, 5'd4, 5'd5));
        vecs.push_back(mkv(32'h8C62_FFFC, 32'h00C, 0, 0, 5'd0, 0, 2'b11, 3'b010, 4'b0001, 32'hAA, 32'h0, 32'hFFFF_FFFC, 5'd2, 5'd31));
        vecs.push_back(mkv(32'h1064_0003, 32'h010, 1, 0, 5'd0, 0, 2'b00, 3'b000, 4'b0000, 32'hAA, 32'h55, 32'h3, 5'd4, 5'd0));
        vecs.push_back(mkv(32'h1064_0003, 32'h014, 0, 0, 5'd0, 0, 2'b00, 3'b100, 4'b0010, 32'hAA, 32'h55, 32'h3, 5'd4, 5'd0));
        vecs.push_back(mkv(32'hAC64_0010, 32'h018, 0, 0, 5'd0, 0, 2'b00, 3'b001, 4'b0001, 32'hAA, 32'h55, 32'h10, 5'd4, 5'd0));
        vecs.push_back(mkv(32'h0800_0000, 32'h01C, 0, 0, 5'd0, 0, 2'b00, 3'b000, 4'b0000, 0, 0, 0, 5'd0, 5'd0));
        // Squash with write-back in the same cycle; r9 must still be written.
        vecs.push_back(mkv(32'h0064_2820, 32'h020, 1, 1, 5'd9, 32'h99, 2'b00, 3'b000, 4'b0000, 32'hAA, 32'h55, 32'h2820, 5'd4, 5'd5));
        vecs.push_back(mkv(32'h0120_0020, 32'h024, 0, 0, 5'd0, 0, 2'b10, 3'b000, 4'b1100, 32'h99, 0, 32'h20, 5'd0, 5'd0));
        // r0 write is ignored, also for any bypass path.
        vecs.push_back(mkv(32'h0000_0000, 32'h028, 0, 1, 5'd0, 32'hDEAD_BEEF, 2'b10, 3'b000, 4'b1100, 0, 0, 0, 5'd0, 5'd0));
        vecs.push_back(mkv(32'h0000_0000, 32'h02C, 0, 0, 5'd0, 0, 2'b10, 3'b000, 4'b1100, 0, 0, 0, 5'd0, 5'd0));
        // Same-cycle write/read of r7 on rs, then on rt.
        vecs.push_back(mkv(32'h00E0_0020, 32'h030, 0, 1, 5'd7, 32'h1234, 2'b10, 3'b000, 4'b1100, byp_r7_a, 0, 32'h20, 5'd0, 5'd0));
        vecs.push_back(mkv(32'h00E0_0020, 32'h034, 0, 0, 5'd0, 0, 2'b10, 3'b000, 4'b1100, 32'h1234, 0, 32'h20, 5'd0, 5'd0));
        vecs.push_back(mkv(32'h0007_0020, 32'h038, 0, 1, 5'd7, 32'h5678, 2'b10, 3'b000, 4'b1100, 0, byp_r7_b, 32'h20, 5'd7, 5'd0));

        // Reset held: outputs must stay zero even with live inputs.
        rst = 1'b1;
        drive(mkv(32'h0064_2820, 32'h4, 0, 1, 5'd5, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        chk_zero("in_reset");

        // Release, then read r5: the write attempted during reset must not land.
        @(negedge clk);
        rst = 1'b0;
        drive(mkv(32'h00A0_0020, 32'h4, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk_all("after_rel", mkv(0, 32'h4, 0, 0, 0, 0, 2'b10, 3'b000, 4'b1100, 0, 0, 32'h20, 5'd0, 5'd0));

        // Reset asserted mid-cycle clears outputs without a clock edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i]);
            @(negedge clk);
        end

        // Reset mid-stream wipes registers; first edge after release latches normally.
        #2;
        rst = 1'b1;
        #1;
        chk_zero("midstream_rst");
        @(negedge clk);
        rst = 1'b0;
        v = mkv(32'h0064_2820, 32'h040, 0, 0, 5'd0, 0, 2'b10, 3'b000, 4'b1100, 0, 0, 32'h2820, 5'd4, 5'd5);
        drive(v);
        @(posedge clk);
        #1;
        chk_all("post_rst", v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/idecode.md
# idecode

Instruction-decode stage of the five-stage MIPS pipeline. It consumes the IF/ID latch produced by `ifetch` (`IF_ID_instr`, `IF_ID_npc`), reads a 32×32 register file, sign-extends the immediate and decodes main control. It captures everything into the ID/EX pipeline latch on each clock edge. It also accepts the MEM/WB write-back port and the `EX_MEM_PCSrc` redirect, and squashes the ID/EX latch on a taken branch.

## Interface
- No parameters. Widths are fixed by the MIPS ISA.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `IF_ID_instr` in 32: fetched instruction.
- `IF_ID_npc` in 32: PC+4 of that instruction.
- `EX_MEM_PCSrc` in 1: taken-branch redirect; squashes the ID/EX latch.
- `MEM_WB_RegWrite` in 1: write-back enable.
- `MEM_WB_WriteReg` in 5: write-back register number.
- `MEM_WB_WriteData` in 32: write-back data.
- `ID_EX_wb` out 2: {RegWrite, MemtoReg}.
- `ID_EX_m` out 3: {Branch, MemRead, MemWrite}.
- `ID_EX_ex` out 4: {RegDst, ALUOp[1:0], ALUSrc}.
- `ID_EX_npc` out 32: latched `IF_ID_npc`.
- `ID_EX_readdat1` out 32: register file value of rs.
- `ID_EX_readdat2` out 32: register file value of rt.
- `ID_EX_sign_ext` out 32: sign-extended `instr[15:0]`.
- `ID_EX_instr_2016` out 5: rt field.
- `ID_EX_instr_1511` out 5: rd field.

## Operation
- **Fields:**
  - opcode = `instr[31:26]`
  - rs = `[25:21]`
  - rt = `[20:16]`
  - rd = `[15:11]`
  - imm = `[15:0]`
- **Control decode** (combinational):
  - R-type 0x00: RegDst=1, ALUOp=10, RegWrite=1, all other control 0.
  - lw 0x23: ALUSrc=1, MemRead=1, MemtoReg=1, RegWrite=1, ALUOp=00.
  - sw 0x2B: ALUSrc=1, MemWrite=1, ALUOp=00.
  - beq 0x04: Branch=1, ALUOp=01.
  - Any other opcode: all control bits 0 (bubble).
- **Sign extension:** `{{16{imm[15]}}, imm}`.
- **Register file:**
  - Two combinational read ports (rs, rt) and one synchronous write port.
  - Write occurs on the rising edge when `MEM_WB_RegWrite`=1 and `MEM_WB_WriteReg`≠0.
  - r0 reads 0 and is never written.
- **ID/EX latch:** on every rising edge, all outputs load their decoded or read values.
- **Squash:** if `EX_MEM_PCSrc`=1 at the edge, `ID_EX_wb`, `ID_EX_m` and `ID_EX_ex` load 0. Data fields still load and are don't-care.
- **Write-back during squash:** a squash does not block the register file write in the same cycle.

## Timing
- **Reset:** while `rst`=1, asynchronously:
  - every ID_EX output is 0;
  - all 32 registers are 0.
- **Latency:** one cycle. IF/ID values present before edge N appear on ID_EX outputs after edge N.
- **Register write:** visible to reads in the cycle after the write edge.
- **Same-cycle read/write of one register:** behaviour depends on `IDECODE_BYPASS_EN` (see Configuration).
- **Reset released mid-stream:** the first edge after deassertion latches the current IF/ID inputs normally. No residue from before reset remains.

## Configuration
- `IDECODE_BYPASS_EN` defined: write-through bypass is compiled in. When `MEM_WB_RegWrite`=1, `MEM_WB_WriteReg`≠0 and it equals rs (or rt), that read port returns `MEM_WB_WriteData` in the same cycle, so ID/EX latches the new value.
- `IDECODE_BYPASS_EN` undefined: read ports return the stored value (old data). The hazard is left to software or to a NOP-insertion unit.

## Structure
- **Shared package `mips_defs`:**
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ;
  - ALUOp encodings;
  - bit positions of the wb/m/ex control bundles.
- **Sub-module `regfile`:** 32×32 storage, 2R1W, async reset, r0 hardwired to 0. It contains the bypass under the macro.
- **Top level:** control decode, sign extension and the ID/EX latch stay in `idecode`.

## Test plan
- **Reset:** assert `rst` mid-cycle -> all outputs 0 immediately. Reading r5 after release -> 0.
- **Write then R-type:** write r3=0x0000_00AA and r4=0x0000_0055 via MEM/WB. Then present `IF_ID_instr`=0x0064_2820 (add r5,r3,r4) with npc=0x8 -> after one edge:
  - `ID_EX_readdat1`=0xAA, `ID_EX_readdat2`=0x55;
  - `ID_EX_ex`=4'b1100, `ID_EX_wb`=2'b10, `ID_EX_npc`=0x8;
  - `ID_EX_instr_1511`=5.
- **lw, negative offset:** 0x8C62_FFFC (lw r2,-4(r3)) -> `ID_EX_sign_ext`=0xFFFF_FFFC, `ID_EX_wb`=2'b11, `ID_EX_m`=3'b010, `ID_EX_ex`=4'b0001.
- **beq with squash:** 0x1064_0003 with `EX_MEM_PCSrc`=1 -> `ID_EX_wb`/`m`/`ex` all 0. Same instruction with PCSrc=0 -> `ID_EX_m`=3'b100, `ID_EX_ex`=4'b0010.
- **r0 write:** write r0=0xDEAD_BEEF, then read r0 -> 0.
- **Same-cycle write/read:** write r7=0x1234 while decoding rs=7 -> `ID_EX_readdat1`=0x1234 with `IDECODE_BYPASS_EN` defined, and the prior value (0) without it.
